// File: rtl/floor_contact.sv
// Per-frame player/floor contact scanner: snapshots the player and five floor boxes on a
// frame tick, tests one floor per clock, and reports contact, landing height and a BCD score.
module floor_contact #(
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 16,
    parameter int FLOOR_W  = 90,
    parameter int CONTACT  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk_i,
    input  logic [9:0] player_x_i,
    input  logic [9:0] player_y_i,
    input  logic [9:0] floor_x_i [0:4],
    input  logic [9:0] floor_y_i [0:4],
    output logic       busy_o,
    output logic       result_valid_o,
    output logic       on_floor_o,
    output logic [2:0] floor_idx_o,
    output logic [9:0] land_y_o,
    output logic [3:0] score1_o,
    output logic [3:0] score0_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic       frame_clk_q;
    logic [9:0] px_q, py_q;
    logic [9:0] fx_q [0:4];
    logic [9:0] fy_q [0:4];
    logic [2:0] idx_q;
    logic       hit_q;
    logic [2:0] hit_idx_q;
    logic [9:0] hit_land_q;
    logic       prev_on_q;
    logic [2:0] prev_idx_q;
    logic       busy_q, result_valid_q, on_floor_q;
    logic [2:0] floor_idx_q;
    logic [9:0] land_y_q;
    logic [3:0] score1_q, score0_q;
    logic [3:0] score1_d, score0_d;

    logic       rise;
    logic [9:0] cur_fx, cur_fy, cur_land;
    logic       floor_hit, landing;
    logic [10:0] bottom, right_edge, fx11, fy11;

    assign rise = frame_clk_i & ~frame_clk_q;

    // Select the floor under test and evaluate the box overlap in 11 bits so nothing wraps.
    always_comb begin
        cur_fx = 10'd0;
        cur_fy = 10'd0;
        case (idx_q)
            3'd0:    begin cur_fx = fx_q[0]; cur_fy = fy_q[0]; end
            3'd1:    begin cur_fx = fx_q[1]; cur_fy = fy_q[1]; end
            3'd2:    begin cur_fx = fx_q[2]; cur_fy = fy_q[2]; end
            3'd3:    begin cur_fx = fx_q[3]; cur_fy = fy_q[3]; end
            3'd4:    begin cur_fx = fx_q[4]; cur_fy = fy_q[4]; end
            default: begin cur_fx = 10'd0;   cur_fy = 10'd0;   end
        endcase
        bottom     = {1'b0, py_q} + 11'(PLAYER_H);
        right_edge = {1'b0, px_q} + 11'(PLAYER_W);
        fx11       = {1'b0, cur_fx};
        fy11       = {1'b0, cur_fy};
        floor_hit  = (fy11 <= bottom) && (bottom <= fy11 + 11'(CONTACT)) &&
                     (right_edge > fx11) && ({1'b0, px_q} < fx11 + 11'(FLOOR_W));
        cur_land   = cur_fy - 10'(PLAYER_H);
    end

    // Score advance: a landing is a hit on a floor other than the one already stood on.
    always_comb begin
        score1_d = score1_q;
        score0_d = score0_q;
        landing  = hit_q & (~prev_on_q | (hit_idx_q != prev_idx_q));
        if (landing && !((score1_q == 4'd9) && (score0_q == 4'd9))) begin
            if (score0_q == 4'd9) begin
                score0_d = 4'd0;
                score1_d = score1_q + 4'd1;
            end else begin
                score0_d = score0_q + 4'd1;
                score1_d = score1_q;
            end
        end else begin
            score1_d = score1_q;
            score0_d = score0_q;
        end
    end

    // Scan FSM with snapshot, first-hit capture and registered results.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            frame_clk_q    <= 1'b0;
            px_q           <= 10'd0;
            py_q           <= 10'd0;
            for (int i = 0; i < 5; i++) begin
                fx_q[i] <= 10'd0;
                fy_q[i] <= 10'd0;
            end
            idx_q          <= 3'd0;
            hit_q          <= 1'b0;
            hit_idx_q      <= 3'd0;
            hit_land_q     <= 10'd0;
            prev_on_q      <= 1'b0;
            prev_idx_q     <= 3'd0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            on_floor_q     <= 1'b0;
            floor_idx_q    <= 3'd0;
            land_y_q       <= 10'd0;
            score1_q       <= 4'd0;
            score0_q       <= 4'd0;
        end else begin
            frame_clk_q <= frame_clk_i;
            case (state_q)
                IDLE: begin
                    result_valid_q <= 1'b0;
                    if (rise) begin
                        px_q <= player_x_i;
                        py_q <= player_y_i;
                        for (int i = 0; i < 5; i++) begin
                            fx_q[i] <= floor_x_i[i];
                            fy_q[i] <= floor_y_i[i];
                        end
                        idx_q      <= 3'd0;
                        hit_q      <= 1'b0;
                        hit_idx_q  <= 3'd0;
                        hit_land_q <= 10'd0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    // Lowest index wins: once a hit is latched, later floors are ignored.
                    if (floor_hit && !hit_q) begin
                        hit_q      <= 1'b1;
                        hit_idx_q  <= idx_q;
                        hit_land_q <= cur_land;
                    end
                    if (idx_q == 3'd4) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                DONE: begin
                    on_floor_q     <= hit_q;
                    floor_idx_q    <= hit_q ? hit_idx_q : 3'd0;
                    land_y_q       <= hit_q ? hit_land_q : 10'd0;
                    score1_q       <= score1_d;
                    score0_q       <= score0_d;
                    prev_on_q      <= hit_q;
                    prev_idx_q     <= hit_q ? hit_idx_q : 3'd0;
                    result_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign result_valid_o = result_valid_q;
    assign on_floor_o     = on_floor_q;
    assign floor_idx_o    = floor_idx_q;
    assign land_y_o       = land_y_q;
    assign score1_o       = score1_q;
    assign score0_o       = score0_q;

endmodule
